// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared encodings for the RV32IF pipeline hazard unit:
//                forwarding selects, register-class tags, scoreboard states
//                and the register-match helper.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

  // Forwarding mux selects seen by the E-stage operand muxes
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Register-class tags attached to every address
  localparam logic REG_INT = 1'b0;
  localparam logic REG_FP  = 1'b1;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_BUSY = 2'd1,
    SB_WB   = 2'd2
  } sb_state_t;

  // Same address in the same register file. Integer x0 is hard-wired zero and
  // never carries a dependency; fp f0 is an ordinary register and does.
  function automatic logic reg_match(input logic [4:0] a, input logic ca,
                                     input logic [4:0] b, input logic cb);
    return (a == b) && (ca == cb) && !((ca == REG_INT) && (a == 5'd0));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit_if
//  Description : Bundle between the datapath and the hazard unit.
//                master : datapath side (drives stage addresses/controls,
//                         receives forwarding, stall, flush, fp write-back)
//                slave  : hazard unit side
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_unit_if;
  import hazard_pkg::*;

  // Stage addresses
  logic [4:0] Rs1D, Rs2D, RdD;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [4:0] RdM, RdW;
  // Register-class tags (REG_FP / REG_INT)
  logic       Rs1FpD, Rs2FpD, RdFpD;
  logic       Rs1FpE, Rs2FpE, RdFpE;
  logic       RdFpM, RdFpW;
  // Stage controls
  logic       RegWriteD, RegWriteE, RegWriteM, RegWriteW;
  logic       ResultSrcE0;
  logic       PCSrcE;
  logic       MulCycD, MulCycE;
  // Pipeline control outputs
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD;
  logic       FlushD, FlushE;
  // Iterative-op scoreboard outputs
  logic       FpBusy;
  logic       FpWbValid;
  logic [4:0] FpWbRd;

  modport master (
    output Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW,
    output Rs1FpD, Rs2FpD, RdFpD, Rs1FpE, Rs2FpE, RdFpE, RdFpM, RdFpW,
    output RegWriteD, RegWriteE, RegWriteM, RegWriteW,
    output ResultSrcE0, PCSrcE, MulCycD, MulCycE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    input  FpBusy, FpWbValid, FpWbRd
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW,
    input  Rs1FpD, Rs2FpD, RdFpD, Rs1FpE, Rs2FpE, RdFpE, RdFpM, RdFpW,
    input  RegWriteD, RegWriteE, RegWriteM, RegWriteW,
    input  ResultSrcE0, PCSrcE, MulCycD, MulCycE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    output FpBusy, FpWbValid, FpWbRd
  );

endinterface
`default_nettype wire

// File: rtl/hazard_unit_fp_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : fp_scoreboard
//  Description : Single-entry scoreboard for iterative FDIV/FSQRT. Accepts an
//                op when idle, counts a fixed latency, then pulses the result
//                write-back for one cycle.
//  Ports       : clk, reset      clock / async active-high reset
//                i_mul_cyc_e     E stage holds an iterative op
//                i_rd_e          its fp destination
//                o_busy          state != IDLE
//                o_wb_valid      one-cycle write-back pulse
//                o_wb_rd         destination for the pulse
//                o_pend_rd       destination currently tracked
//  Revision    : 1.0  initial release
// ============================================================================
module fp_scoreboard
  import hazard_pkg::*;
#(
  parameter int FDIV_LAT = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       i_mul_cyc_e,
  input  wire logic [4:0] i_rd_e,
  output logic            o_busy,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic [4:0]      o_pend_rd
);

  localparam int CNT_W = $clog2(FDIV_LAT);

  // Accept cycle c -> BUSY from c+1 with FDIV_LAT-2 left, reaching 0 in cycle
  // c+FDIV_LAT-1, so WB lands exactly in cycle c+FDIV_LAT.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FDIV_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sb_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_pend_rd;
  logic             r_busy;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= SB_IDLE;
      r_cnt      <= '0;
      r_pend_rd  <= '0;
      r_busy     <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
    end else begin
      case (r_state)
        SB_IDLE: begin
          if (i_mul_cyc_e) begin
            r_state   <= SB_BUSY;
            r_cnt     <= CNT_LOAD;
            r_pend_rd <= i_rd_e;
            r_busy    <= 1'b1;
          end
        end
        // A second iterative op in E while not idle cannot legally occur
        // (MulCycD stalls it in D); it is simply ignored here.
        SB_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_state    <= SB_WB;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_pend_rd;
          end
        end
        SB_WB: begin
          r_state    <= SB_IDLE;
          r_busy     <= 1'b0;
          r_wb_valid <= 1'b0;
          r_wb_rd    <= '0;
        end
        default: begin
          r_state    <= SB_IDLE;
          r_busy     <= 1'b0;
          r_wb_valid <= 1'b0;
          r_wb_rd    <= '0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_wb_valid = r_wb_valid;
  assign o_wb_rd    = r_wb_rd;
  assign o_pend_rd  = r_pend_rd;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Pipeline control for the 5-stage RV32IF datapath: operand
//                forwarding, load-use and scoreboard stalls, branch flushes,
//                and the write-back pulse for iterative FDIV/FSQRT results.
//  Ports       : clk, reset  clock / async active-high reset
//                hz (slave)  stage addresses, class tags and controls in;
//                            ForwardAE/BE, StallF/D, FlushD/E, FpBusy,
//                            FpWbValid, FpWbRd out
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int FDIV_LAT = 16
) (
  input  wire logic   clk,
  input  wire logic   reset,
  hazard_unit_if.slave hz
);

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_lw_stall;
  logic       w_sb_stall;
  logic       w_stall;
  logic       w_busy;
  logic       w_wb_valid;
  logic [4:0] w_wb_rd;
  logic [4:0] w_pend_rd;

  fp_scoreboard #(
    .FDIV_LAT (FDIV_LAT)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .i_mul_cyc_e (hz.MulCycE),
    .i_rd_e      (hz.RdE),
    .o_busy      (w_busy),
    .o_wb_valid  (w_wb_valid),
    .o_wb_rd     (w_wb_rd),
    .o_pend_rd   (w_pend_rd)
  );

  // M is the younger producer, so it wins over W.
  always_comb begin
    w_fwd_a = FWD_RF;
    if (hz.RegWriteM && reg_match(hz.RdM, hz.RdFpM, hz.Rs1E, hz.Rs1FpE))
      w_fwd_a = FWD_M;
    else if (hz.RegWriteW && reg_match(hz.RdW, hz.RdFpW, hz.Rs1E, hz.Rs1FpE))
      w_fwd_a = FWD_W;
  end

  always_comb begin
    w_fwd_b = FWD_RF;
    if (hz.RegWriteM && reg_match(hz.RdM, hz.RdFpM, hz.Rs2E, hz.Rs2FpE))
      w_fwd_b = FWD_M;
    else if (hz.RegWriteW && reg_match(hz.RdW, hz.RdFpW, hz.Rs2E, hz.Rs2FpE))
      w_fwd_b = FWD_W;
  end

  assign w_lw_stall = hz.ResultSrcE0 && hz.RegWriteE &&
                      (reg_match(hz.RdE, hz.RdFpE, hz.Rs1D, hz.Rs1FpD) ||
                       reg_match(hz.RdE, hz.RdFpE, hz.Rs2D, hz.Rs2FpD));

  // RAW on the pending fp destination, WAW on it, or a second iterative op
  // wanting the single scoreboard entry. Stays high through the WB cycle so
  // the reader issues only once the register file holds the result.
  assign w_sb_stall = w_busy &&
                      (((hz.Rs1FpD == REG_FP) && (hz.Rs1D == w_pend_rd)) ||
                       ((hz.Rs2FpD == REG_FP) && (hz.Rs2D == w_pend_rd)) ||
                       (hz.RegWriteD && (hz.RdFpD == REG_FP) && (hz.RdD == w_pend_rd)) ||
                       hz.MulCycD);

  // A taken branch discards D anyway; stalling would lose its target PC.
  assign w_stall = (w_lw_stall || w_sb_stall) && !hz.PCSrcE;

  assign hz.ForwardAE = w_fwd_a;
  assign hz.ForwardBE = w_fwd_b;
  assign hz.StallF    = w_stall;
  assign hz.StallD    = w_stall;
  assign hz.FlushD    = hz.PCSrcE;
  assign hz.FlushE    = hz.PCSrcE || w_lw_stall || w_sb_stall;
  assign hz.FpBusy    = w_busy;
  assign hz.FpWbValid = w_wb_valid;
  assign hz.FpWbRd    = w_wb_rd;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Self-checking bench for hazard_unit with FDIV_LAT = 4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_unit;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  hazard_unit_if hif ();

  hazard_unit #(.FDIV_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The scoreboard is described by the cycle an op was accepted: busy in the
  // LAT cycles after it, write-back in the last of them.
  int         cyc = 0;
  int         acc_c = -100;
  logic [4:0] acc_rd = '0;

  function automatic bit m_busy();
    return (cyc >= acc_c + 1) && (cyc <= acc_c + LAT);
  endfunction

  function automatic bit m_wb();
    return cyc == acc_c + LAT;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) acc_c <= -100;
    else if (hif.MulCycE && !m_busy()) begin
      acc_c  <= cyc;
      acc_rd <= hif.RdE;
    end
  end

  function automatic bit mt(logic [4:0] a, logic ca, logic [4:0] b, logic cb);
    if (a != b || ca != cb) return 1'b0;
    if (ca == 1'b0 && a == 5'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [1:0] m_fwd(logic [4:0] rs, logic fp);
    if (hif.RegWriteM && mt(hif.RdM, hif.RdFpM, rs, fp)) return 2'b10;
    if (hif.RegWriteW && mt(hif.RdW, hif.RdFpW, rs, fp)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_lw();
    return hif.ResultSrcE0 && hif.RegWriteE &&
           (mt(hif.RdE, hif.RdFpE, hif.Rs1D, hif.Rs1FpD) ||
            mt(hif.RdE, hif.RdFpE, hif.Rs2D, hif.Rs2FpD));
  endfunction

  function automatic bit m_sb();
    if (!m_busy()) return 1'b0;
    return (hif.Rs1FpD && hif.Rs1D == acc_rd) || (hif.Rs2FpD && hif.Rs2D == acc_rd) ||
           (hif.RegWriteD && hif.RdFpD && hif.RdD == acc_rd) || hif.MulCycD;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    hif.Rs1D = 0; hif.Rs2D = 0; hif.RdD = 0; hif.Rs1E = 0; hif.Rs2E = 0;
    hif.RdE = 0; hif.RdM = 0; hif.RdW = 0;
    hif.Rs1FpD = 0; hif.Rs2FpD = 0; hif.RdFpD = 0; hif.Rs1FpE = 0;
    hif.Rs2FpE = 0; hif.RdFpE = 0; hif.RdFpM = 0; hif.RdFpW = 0;
    hif.RegWriteD = 0; hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
    hif.ResultSrcE0 = 0; hif.PCSrcE = 0; hif.MulCycD = 0; hif.MulCycE = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    n_checks++; if (hif.ForwardAE !== 2'b00) begin n_fail++; $display("FAIL reset_fwdA: got %b expected 00", hif.ForwardAE); end
    n_checks++; if (hif.ForwardBE !== 2'b00) begin n_fail++; $display("FAIL reset_fwdB: got %b expected 00", hif.ForwardBE); end
    n_checks++; if ({hif.StallF, hif.StallD, hif.FlushD, hif.FlushE} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_stall_flush: got %b expected 0000", {hif.StallF, hif.StallD, hif.FlushD, hif.FlushE}); end
    n_checks++; if ({hif.FpBusy, hif.FpWbValid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_sb: busy/wbvalid got %b expected 00", {hif.FpBusy, hif.FpWbValid}); end
    n_checks++; if (hif.FpWbRd !== 5'd0) begin n_fail++; $display("FAIL reset_wbrd: got %0d expected 0", hif.FpWbRd); end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    hif.RegWriteM = 1; hif.RegWriteW = 1; hif.RdM = 5; hif.RdW = 5; hif.Rs1E = 5;
    #1;
    n_checks++; if (hif.ForwardAE !== 2'b10) begin n_fail++; $display("FAIL fwd_m_over_w: got %b expected 10", hif.ForwardAE); end
    hif.RegWriteM = 0;
    #1;
    n_checks++; if (hif.ForwardAE !== 2'b01) begin n_fail++; $display("FAIL fwd_w: got %b expected 01", hif.ForwardAE); end
    clear_inputs();
    hif.RegWriteM = 1; hif.RdM = 0; hif.Rs2E = 0;
    #1;
    n_checks++; if (hif.ForwardBE !== 2'b00) begin n_fail++; $display("FAIL fwd_x0: got %b expected 00", hif.ForwardBE); end
    hif.RdFpM = 1; hif.Rs2FpE = 1;
    #1;
    n_checks++; if (hif.ForwardBE !== 2'b10) begin n_fail++; $display("FAIL fwd_f0: got %b expected 10", hif.ForwardBE); end
    hif.Rs2FpE = 0;
    #1;
    n_checks++; if (hif.ForwardBE !== 2'b00) begin n_fail++; $display("FAIL fwd_class_mismatch: got %b expected 00", hif.ForwardBE); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    hif.ResultSrcE0 = 1; hif.RegWriteE = 1; hif.RdE = 7; hif.Rs2D = 7;
    #1;
    n_checks++; if ({hif.StallF, hif.StallD, hif.FlushD, hif.FlushE} !== 4'b1101) begin
      n_fail++; $display("FAIL load_use: StallF/StallD/FlushD/FlushE got %b expected 1101", {hif.StallF, hif.StallD, hif.FlushD, hif.FlushE}); end
    hif.PCSrcE = 1;
    #1;
    n_checks++; if ({hif.StallF, hif.StallD, hif.FlushD, hif.FlushE} !== 4'b0011) begin
      n_fail++; $display("FAIL load_use_branch: StallF/StallD/FlushD/FlushE got %b expected 0011", {hif.StallF, hif.StallD, hif.FlushD, hif.FlushE}); end
    clear_inputs();
  endtask

  task automatic test_scoreboard();
    clear_inputs();
    next_cycle();
    hif.MulCycE = 1; hif.RdE = 3; hif.RdFpE = 1;      // accepted this cycle (c)
    next_cycle();
    hif.MulCycE = 0; hif.RdE = 0; hif.RdFpE = 0;
    for (int k = 1; k <= 5; k++) begin
      hif.Rs1D = 3; hif.Rs1FpD = 1;
      #2;
      n_checks++; if (hif.FpBusy !== (k <= LAT)) begin n_fail++; $display("FAIL sb_busy c+%0d: got %b expected %b", k, hif.FpBusy, k <= LAT); end
      n_checks++; if (hif.FpWbValid !== (k == LAT)) begin n_fail++; $display("FAIL sb_wbvalid c+%0d: got %b expected %b", k, hif.FpWbValid, k == LAT); end
      if (k == LAT) begin
        n_checks++; if (hif.FpWbRd !== 5'd3) begin n_fail++; $display("FAIL sb_wbrd: got %0d expected 3", hif.FpWbRd); end
      end
      n_checks++; if ({hif.StallF, hif.StallD} !== {2{k <= LAT}}) begin
        n_fail++; $display("FAIL sb_raw_stall c+%0d: got %b expected %b", k, {hif.StallF, hif.StallD}, {2{k <= LAT}}); end
      hif.Rs1FpD = 0;                                  // x3 instead of f3
      #1;
      n_checks++; if (hif.StallD !== 1'b0) begin n_fail++; $display("FAIL sb_int_no_stall c+%0d: got %b expected 0", k, hif.StallD); end
      if (k < 5) next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_struct_waw();
    clear_inputs();
    next_cycle();
    hif.MulCycE = 1; hif.RdE = 3; hif.RdFpE = 1;
    next_cycle();
    clear_inputs();
    hif.MulCycD = 1;
    #1;
    n_checks++; if (hif.StallD !== 1'b1) begin n_fail++; $display("FAIL struct_stall: got %b expected 1", hif.StallD); end
    hif.MulCycD = 0; hif.RegWriteD = 1; hif.RdFpD = 1; hif.RdD = 3;
    #1;
    n_checks++; if (hif.StallD !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %b expected 1", hif.StallD); end
    hif.RdD = 4;
    #1;
    n_checks++; if (hif.StallD !== 1'b0) begin n_fail++; $display("FAIL waw_other_rd: got %b expected 0", hif.StallD); end
    clear_inputs();
    repeat (LAT + 1) next_cycle();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    next_cycle();
    hif.MulCycE = 1; hif.RdE = 9; hif.RdFpE = 1;      // held high throughout
    for (int k = 1; k <= 2 * LAT + 2; k++) begin
      next_cycle();
      #1;
      n_checks++; if (hif.FpWbValid !== (k == LAT || k == 2 * LAT + 1)) begin
        n_fail++; $display("FAIL b2b_wbvalid c+%0d: got %b expected %b", k, hif.FpWbValid, k == LAT || k == 2 * LAT + 1); end
    end
    clear_inputs();
    repeat (LAT + 1) next_cycle();
  endtask

  task automatic test_reset_midop();
    clear_inputs();
    next_cycle();
    hif.MulCycE = 1; hif.RdE = 3; hif.RdFpE = 1;
    next_cycle();
    clear_inputs();
    next_cycle();                                      // c+2
    #2 reset = 1'b1;
    #1;
    n_checks++; if (hif.FpBusy !== 1'b0) begin n_fail++; $display("FAIL midop_reset_busy: got %b expected 0", hif.FpBusy); end
    #1 reset = 1'b0;
    for (int k = 0; k < 2 * LAT; k++) begin
      next_cycle();
      #1;
      n_checks++; if ({hif.FpBusy, hif.FpWbValid} !== 2'b00) begin
        n_fail++; $display("FAIL midop_no_wb step %0d: busy/wbvalid got %b expected 00", k, {hif.FpBusy, hif.FpWbValid}); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      next_cycle();
      hif.Rs1D = 5'($urandom_range(0, 3)); hif.Rs2D = 5'($urandom_range(0, 3));
      hif.RdD  = 5'($urandom_range(0, 3)); hif.Rs1E = 5'($urandom_range(0, 3));
      hif.Rs2E = 5'($urandom_range(0, 3)); hif.RdE  = 5'($urandom_range(0, 3));
      hif.RdM  = 5'($urandom_range(0, 3)); hif.RdW  = 5'($urandom_range(0, 3));
      hif.Rs1FpD = 1'($urandom); hif.Rs2FpD = 1'($urandom); hif.RdFpD = 1'($urandom);
      hif.Rs1FpE = 1'($urandom); hif.Rs2FpE = 1'($urandom); hif.RdFpE = 1'($urandom);
      hif.RdFpM = 1'($urandom); hif.RdFpW = 1'($urandom);
      hif.RegWriteD = 1'($urandom); hif.RegWriteE = 1'($urandom);
      hif.RegWriteM = 1'($urandom); hif.RegWriteW = 1'($urandom);
      hif.ResultSrcE0 = 1'($urandom); hif.PCSrcE = ($urandom_range(0, 5) == 0);
      hif.MulCycD = ($urandom_range(0, 5) == 0);
      hif.MulCycE = ($urandom_range(0, 4) == 0);
      #2;
      n_checks++; if (hif.ForwardAE !== m_fwd(hif.Rs1E, hif.Rs1FpE)) begin
        n_fail++; $display("FAIL rnd_fwdA cyc %0d: got %b expected %b", cyc, hif.ForwardAE, m_fwd(hif.Rs1E, hif.Rs1FpE)); end
      n_checks++; if (hif.ForwardBE !== m_fwd(hif.Rs2E, hif.Rs2FpE)) begin
        n_fail++; $display("FAIL rnd_fwdB cyc %0d: got %b expected %b", cyc, hif.ForwardBE, m_fwd(hif.Rs2E, hif.Rs2FpE)); end
      n_checks++; if (hif.StallF !== ((m_lw() || m_sb()) && !hif.PCSrcE)) begin
        n_fail++; $display("FAIL rnd_stallF cyc %0d: got %b expected %b", cyc, hif.StallF, (m_lw() || m_sb()) && !hif.PCSrcE); end
      n_checks++; if (hif.StallD !== ((m_lw() || m_sb()) && !hif.PCSrcE)) begin
        n_fail++; $display("FAIL rnd_stallD cyc %0d: got %b expected %b", cyc, hif.StallD, (m_lw() || m_sb()) && !hif.PCSrcE); end
      n_checks++; if (hif.FlushD !== hif.PCSrcE) begin
        n_fail++; $display("FAIL rnd_flushD cyc %0d: got %b expected %b", cyc, hif.FlushD, hif.PCSrcE); end
      n_checks++; if (hif.FlushE !== (hif.PCSrcE || m_lw() || m_sb())) begin
        n_fail++; $display("FAIL rnd_flushE cyc %0d: got %b expected %b", cyc, hif.FlushE, hif.PCSrcE || m_lw() || m_sb()); end
      n_checks++; if (hif.FpBusy !== m_busy()) begin
        n_fail++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", cyc, hif.FpBusy, m_busy()); end
      n_checks++; if (hif.FpWbValid !== m_wb()) begin
        n_fail++; $display("FAIL rnd_wbvalid cyc %0d: got %b expected %b", cyc, hif.FpWbValid, m_wb()); end
      if (m_wb()) begin
        n_checks++; if (hif.FpWbRd !== acc_rd) begin
          n_fail++; $display("FAIL rnd_wbrd cyc %0d: got %0d expected %0d", cyc, hif.FpWbRd, acc_rd); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_scoreboard();
    test_struct_waw();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
